// File: rtl/bus_pkg.sv
// Shared definitions for the internal read-bus multiplexer.
// Holds the lane-format mode encodings, the idle select value and the
// request legality check used by the formatter.
package bus_pkg;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_HI   = 2'd1;
   localparam logic [1:0] MODE_CAT  = 2'd2;
   localparam logic [1:0] MODE_RSV  = 2'd3;

   localparam int unsigned SEL_IDLE = 0;

   // A request is legal when it names an existing source, uses a defined mode,
   // and, for concatenation, the companion source sel+1 also exists.
   function automatic logic req_legal(input int unsigned sel,
                                      input logic [1:0]  mode,
                                      input int unsigned n_src);
      logic ok;
      ok = (sel >= 1) && (sel <= n_src) && (mode != MODE_RSV);
      if (mode == MODE_CAT) begin
         ok = ok && (sel <= n_src - 1);
      end
      return ok;
   endfunction

endpackage

// File: rtl/bus_lane_fmt.sv
// Combinational source selection and lane formatting.
// Ports:
//   read_en  - 1-based source select (0 = idle)
//   mode     - lane format (pass / high-half / concat / reserved)
//   src_flat - all sources packed, source k at [k*W-1 : (k-1)*W]
//   word     - formatted bus word
//   legal    - request is legal (idle and illegal selects both give 0)
module bus_lane_fmt
   import bus_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned N_SRC = 17,
   parameter int unsigned SEL_W = 5
) (
   input  logic [SEL_W-1:0]   read_en,
   input  logic [1:0]         mode,
   input  logic [N_SRC*W-1:0] src_flat,
   output logic [W-1:0]       word,
   output logic               legal
);

   logic [W-1:0] s_word;
   logic [W-1:0] t_word;

   // Decode by loop so out-of-range selects never form an out-of-range slice.
   always_comb begin
      s_word = '0;
      t_word = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         if (read_en == SEL_W'(k)) begin
            s_word = src_flat[(k-1)*W +: W];
            if (k < N_SRC) begin
               t_word = src_flat[k*W +: W];
            end
         end
      end
   end

   always_comb begin
      legal = req_legal(32'(read_en), mode, N_SRC);
      unique case (mode)
         MODE_HI:  word = {{(W/2){1'b0}}, s_word[W-1:W/2]};
         MODE_CAT: word = {s_word[W/2-1:0], t_word[W/2-1:0]};
         default:  word = s_word;
      endcase
   end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered internal read-bus multiplexer.
// Selects one of N_SRC sources, formats it and registers it onto the bus with
// one cycle of latency. Idle and illegal requests hold the bus value.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   read_en    - 1-based source select, 0 = no driver
//   mode       - 0 pass, 1 high-half, 2 concat with source read_en+1, 3 reserved
//   src_flat   - packed sources
//   err_clr    - clears sel_err (an illegal request on the same edge wins)
//   busIn      - registered bus value
//   bus_valid  - busIn was loaded by the previous cycle's request
//   sel_err    - sticky illegal-select flag
//   xfer_cnt   - saturating count of legal transfers
module bus_mux_reg
   import bus_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned N_SRC = 17,
   parameter int unsigned SEL_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SEL_W-1:0]   read_en,
   input  logic [1:0]         mode,
   input  logic [N_SRC*W-1:0] src_flat,
   input  logic               err_clr,
   output logic [W-1:0]       busIn,
   output logic               bus_valid,
   output logic               sel_err,
   output logic [CNT_W-1:0]   xfer_cnt
);

   logic [W-1:0] fmt_word;
   logic         fmt_legal;
   logic         req_idle;

   bus_lane_fmt #(
      .W     (W),
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_fmt (
      .read_en  (read_en),
      .mode     (mode),
      .src_flat (src_flat),
      .word     (fmt_word),
      .legal    (fmt_legal)
   );

   assign req_idle = (read_en == SEL_W'(SEL_IDLE));

   always_ff @(posedge clk) begin
      if (rst) begin
         busIn     <= '0;
         bus_valid <= 1'b0;
         sel_err   <= 1'b0;
         xfer_cnt  <= '0;
      end else begin
         bus_valid <= fmt_legal;
         if (fmt_legal) begin
            busIn <= fmt_word;
            if (xfer_cnt != {CNT_W{1'b1}}) begin
               xfer_cnt <= xfer_cnt + 1'b1;
            end
         end
         if (!fmt_legal && !req_idle) begin
            sel_err <= 1'b1;
         end else if (err_clr) begin
            sel_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bus_mux_reg.sv
module tb_bus_mux_reg;

   localparam int unsigned W     = 16;
   localparam int unsigned N_SRC = 17;
   localparam int unsigned SEL_W = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic [SEL_W-1:0]   read_en;
   logic [1:0]         mode;
   logic [N_SRC*W-1:0] src_flat;
   logic               err_clr;
   logic [W-1:0]       bus_a, bus_b;
   logic               valid_a, valid_b;
   logic               err_a, err_b;
   logic [15:0]        cnt_a;
   logic [3:0]         cnt_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bus_mux_reg #(.W(W), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .read_en(read_en), .mode(mode), .src_flat(src_flat),
      .err_clr(err_clr), .busIn(bus_a), .bus_valid(valid_a), .sel_err(err_a),
      .xfer_cnt(cnt_a)
   );

   bus_mux_reg #(.W(W), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .read_en(read_en), .mode(mode), .src_flat(src_flat),
      .err_clr(err_clr), .busIn(bus_b), .bus_valid(valid_b), .sel_err(err_b),
      .xfer_cnt(cnt_b)
   );

   task automatic set_src(input int k, input logic [W-1:0] v);
      src_flat[(k-1)*W +: W] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; read_en = 5'd4; mode = 2'd0; err_clr = 1'b0;
      set_src(4, 16'h1111);
      step();
      tests++; if (bus_a !== 16'h0) begin fails++; $display("FAIL rst_bus got %h want 0000", bus_a); end
      tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", valid_a); end
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err_a); end
      tests++; if (cnt_a !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d want 0", cnt_a); end
      rst = 1'b0;
   endtask

   task automatic test_pass();
      read_en = 5'd4; mode = 2'd0; set_src(4, 16'hA5C3);
      step();
      tests++; if (bus_a !== 16'hA5C3) begin fails++; $display("FAIL pass_bus got %h want a5c3", bus_a); end
      tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL pass_valid got %b want 1", valid_a); end
      tests++; if (cnt_a !== 16'd1) begin fails++; $display("FAIL pass_cnt got %0d want 1", cnt_a); end
   endtask

   task automatic test_hi_hold();
      read_en = 5'd12; mode = 2'd1; set_src(12, 16'hBEEF);
      step();
      tests++; if (bus_a !== 16'h00BE) begin fails++; $display("FAIL hi_bus got %h want 00be", bus_a); end
      tests++; if (cnt_a !== 16'd2) begin fails++; $display("FAIL hi_cnt got %0d want 2", cnt_a); end
      read_en = 5'd0; set_src(12, 16'h7777);
      step();
      tests++; if (bus_a !== 16'h00BE) begin fails++; $display("FAIL idle_bus got %h want 00be", bus_a); end
      tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL idle_valid got %b want 0", valid_a); end
      tests++; if (cnt_a !== 16'd2) begin fails++; $display("FAIL idle_cnt got %0d want 2", cnt_a); end
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL idle_err got %b want 0", err_a); end
   endtask

   task automatic test_concat();
      read_en = 5'd1; mode = 2'd2; set_src(1, 16'h12AB); set_src(2, 16'h34CD);
      step();
      tests++; if (bus_a !== 16'hABCD) begin fails++; $display("FAIL cat_bus got %h want abcd", bus_a); end
      tests++; if (cnt_a !== 16'd3) begin fails++; $display("FAIL cat_cnt got %0d want 3", cnt_a); end
      // Highest legal concat select pairs sources 16 and 17.
      read_en = 5'd16; set_src(16, 16'h9E01); set_src(17, 16'h5F02);
      step();
      tests++; if (bus_a !== 16'h0102) begin fails++; $display("FAIL cat16_bus got %h want 0102", bus_a); end
      tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL cat16_valid got %b want 1", valid_a); end
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL cat16_err got %b want 0", err_a); end
      read_en = 5'd17;
      step();
      tests++; if (bus_a !== 16'h0102) begin fails++; $display("FAIL cat17_bus got %h want 0102", bus_a); end
      tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL cat17_valid got %b want 0", valid_a); end
      tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL cat17_err got %b want 1", err_a); end
      tests++; if (cnt_a !== 16'd4) begin fails++; $display("FAIL cat17_cnt got %0d want 4", cnt_a); end
   endtask

   task automatic test_err_clr();
      read_en = 5'd20; mode = 2'd0; err_clr = 1'b1;
      step();
      tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL setwins_err got %b want 1", err_a); end
      read_en = 5'd0;
      step();
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL clr_err got %b want 0", err_a); end
      tests++; if (bus_a !== 16'h0102) begin fails++; $display("FAIL clr_bus got %h want 0102", bus_a); end
      err_clr = 1'b0; mode = 2'd3; read_en = 5'd5; set_src(5, 16'hDDDD);
      step();
      tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL rsv_err got %b want 1", err_a); end
      tests++; if (bus_a !== 16'h0102) begin fails++; $display("FAIL rsv_bus got %h want 0102", bus_a); end
      tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL rsv_valid got %b want 0", valid_a); end
      // Clear alongside a legal transfer: transfer proceeds normally.
      err_clr = 1'b1; mode = 2'd0; read_en = 5'd17; set_src(17, 16'h4242);
      step();
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL clrleg_err got %b want 0", err_a); end
      tests++; if (bus_a !== 16'h4242) begin fails++; $display("FAIL clrleg_bus got %h want 4242", bus_a); end
      tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL clrleg_valid got %b want 1", valid_a); end
      tests++; if (cnt_a !== 16'd5) begin fails++; $display("FAIL clrleg_cnt got %0d want 5", cnt_a); end
      err_clr = 1'b0;
   endtask

   task automatic test_saturate();
      rst = 1'b1; read_en = 5'd0;
      step();
      rst = 1'b0; read_en = 5'd4; mode = 2'd0; set_src(4, 16'hC0DE);
      for (int i = 0; i < 16; i++) step();
      tests++; if (cnt_b !== 4'd15) begin fails++; $display("FAIL sat16_cnt got %0d want 15", cnt_b); end
      step();
      tests++; if (cnt_b !== 4'd15) begin fails++; $display("FAIL sat17_cnt got %0d want 15", cnt_b); end
      tests++; if (cnt_a !== 16'd17) begin fails++; $display("FAIL wide17_cnt got %0d want 17", cnt_a); end
      tests++; if (bus_b !== 16'hC0DE) begin fails++; $display("FAIL sat_bus got %h want c0de", bus_b); end
      read_en = 5'd30;
      step();
      tests++; if (err_b !== 1'b1) begin fails++; $display("FAIL sat_err got %b want 1", err_b); end
      // Reset together with a legal request clears everything.
      rst = 1'b1; read_en = 5'd4;
      step();
      tests++; if (bus_b !== 16'h0) begin fails++; $display("FAIL midrst_bus got %h want 0000", bus_b); end
      tests++; if (valid_b !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", valid_b); end
      tests++; if (err_b !== 1'b0) begin fails++; $display("FAIL midrst_err got %b want 0", err_b); end
      tests++; if (cnt_b !== 4'd0) begin fails++; $display("FAIL midrst_cnt got %0d want 0", cnt_b); end
      tests++; if (cnt_a !== 16'd0) begin fails++; $display("FAIL midrst_wcnt got %0d want 0", cnt_a); end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; read_en = '0; mode = '0; err_clr = 1'b0; src_flat = '0;
      #1;
      test_reset();
      test_pass();
      test_hi_hold();
      test_concat();
      test_err_clr();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised successor to the datapath read-bus multiplexer; selects one of N_SRC register/memory sources onto the shared internal bus feeding the matrix-multiply core's ALU and register file.
- Adds a registered output, explicit hold on idle, lane-format modes (high-half extract, two-source concatenate), a sticky select-error flag and a saturating transfer counter.
- Sits between all bus-readable registers and every bus consumer.
- The control unit drives the read-enable select each cycle.

Parameters:
- W, 16, bus width in bits; must be even, minimum 4.
- N_SRC, 17, number of bus sources, numbered 1..N_SRC; minimum 2.
- SEL_W, 5, select width; must satisfy 2^SEL_W > N_SRC.
- CNT_W, 16, transfer-counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- read_en  input  SEL_W  source select; 0 means no driver.
- mode  input  2  0 = pass, 1 = high-half, 2 = concat, 3 = reserved.
- src_flat  input  N_SRC*W  source k (1-based) occupies bits [k*W-1 : (k-1)*W]. Narrower registers are zero-extended by the instantiating level.
- err_clr  input  1  clears sel_err.
- busIn  output  W  registered bus value.
- bus_valid  output  1  busIn updated by the previous cycle's request.
- sel_err  output  1  sticky illegal-select flag.
- xfer_cnt  output  CNT_W  count of valid transfers; saturating.

Behaviour:
- Reset: the design has one clock; reset is synchronous and active-high. While rst=1 at a clock edge: busIn=0, bus_valid=0, sel_err=0, xfer_cnt=0. Reset overrides every other input, including mid-sequence requests.
- Latency: exactly 1 cycle. A request presented on cycle t produces busIn and bus_valid after edge t+1.
- A request is legal when 1 <= read_en <= N_SRC, mode != 3, and, for mode 2 only, read_en <= N_SRC-1.
- Data formatting for a legal request, with S = source read_en:
  - Mode 0: busIn = S.
  - Mode 1: busIn = zero-extended S[W-1 : W/2].
  - Mode 2: busIn = {S[W/2-1:0], T[W/2-1:0]}, where T = source read_en+1 and S fills the upper half.
- Legal request: busIn loads the formatted value; bus_valid=1; xfer_cnt increments by 1 and saturates at 2^CNT_W-1 with no wrap.
- read_en = 0 (idle): busIn holds its previous value; bus_valid=0; sel_err and xfer_cnt unchanged. The hold is an explicit register, never an inferred latch.
- Illegal request (read_en > N_SRC, mode 3, or mode 2 with read_en = N_SRC): busIn holds; bus_valid=0; sel_err sets to 1; xfer_cnt unchanged.
- sel_err stays at 1 until err_clr=1 at a clock edge.
- err_clr=1 together with an illegal request on the same edge: set wins, so sel_err=1.
- err_clr has no effect on busIn, bus_valid or xfer_cnt.
- Source values are sampled only at the edge; source changes between edges have no effect on busIn.

Decomposition:
- Shared package bus_pkg holds:
  - mode constants MODE_PASS=2'd0, MODE_HI=2'd1, MODE_CAT=2'd2, MODE_RSV=2'd3;
  - SEL_IDLE = 0;
  - a function computing the legality check.
- One combinational sub-module, bus_lane_fmt (W, N_SRC, SEL_W), performs source selection and lane formatting and produces the formatted word plus a legal flag.
- The top level contains only the busIn/bus_valid register, the sel_err flag and the xfer_cnt counter.

Test Plan:
- Reset, then read_en=4, mode=0, source 4 = 16'hA5C3 -> after 1 edge: busIn=16'hA5C3, bus_valid=1, xfer_cnt=1.
- read_en=12, mode=1, source 12 = 16'hBEEF -> busIn=16'h00BE. Next cycle read_en=0 -> busIn stays 16'h00BE, bus_valid=0, xfer_cnt unchanged.
- read_en=1, mode=2, source 1 = 16'h12AB, source 2 = 16'h34CD -> busIn=16'hABCD. Then read_en=17, mode=2 -> busIn holds 16'hABCD, bus_valid=0, sel_err=1.
- read_en=20, err_clr=1 on the same edge -> sel_err=1. Next cycle err_clr=1, read_en=0 -> sel_err=0. Then mode=3, read_en=5 -> sel_err=1, busIn unchanged.
- Preload with CNT_W=4: 16 legal requests -> xfer_cnt=15 and stays 15. Assert rst mid-stream alongside a legal request -> all outputs 0 on that edge.
